// File: rtl/imm_extend_stage.sv
// imm_extend_stage: decodes the immediate of one RV32/RV64 instruction per
// cycle, covering the base formats and the RVC CI/CIW/CJ/CB formats. Each
// decoded immediate, its illegal flag and its sideband tag are captured as one
// entry. A main register drives the outputs, and a skid register holds one
// overflow entry, so InReady never depends combinationally on OutReady.
module imm_extend_stage #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 Flush,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [31:0]          Instr,
  input  logic [3:0]           ImmSel,
  input  logic [TAG_WIDTH-1:0] InTag,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [XLEN-1:0]      Imm,
  output logic                 ImmIllegal,
  output logic [TAG_WIDTH-1:0] OutTag
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [XLEN-1:0]      dec_imm;
  logic                 dec_illegal;

  logic [XLEN-1:0]      main_imm;
  logic                 main_illegal;
  logic [TAG_WIDTH-1:0] main_tag;
  logic [XLEN-1:0]      skid_imm;
  logic                 skid_illegal;
  logic [TAG_WIDTH-1:0] skid_tag;

  logic accept;
  logic drain;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  // Instr[1:0] is only the opcode quadrant and carries no immediate bits.
  logic unused_bits;
  assign unused_bits = ^Instr[1:0];

  // Both valid bits come from the state register, so InReady is registered.
  assign OutValid = (state != EMPTY);
  assign InReady  = (state != FULL);
  assign accept   = InValid & InReady;
  assign drain    = OutValid & OutReady;

  assign Imm        = main_imm;
  assign ImmIllegal = main_illegal;
  assign OutTag     = main_tag;

  // Immediate decode: fill with the sign (or zero) first, then place the field.
  always_comb begin
    dec_imm     = '0;
    dec_illegal = 1'b0;
    case (ImmSel)
      4'd0: begin
        dec_imm       = {XLEN{Instr[31]}};
        dec_imm[11:0] = Instr[31:20];
      end
      4'd1: begin
        dec_imm[4:0] = Instr[24:20];
        if (XLEN == 64) dec_imm[5] = Instr[25];
      end
      4'd2: begin
        dec_imm       = {XLEN{Instr[31]}};
        dec_imm[11:0] = {Instr[31:25], Instr[11:7]};
      end
      4'd3: begin
        dec_imm        = {XLEN{Instr[31]}};
        dec_imm[31:0]  = {Instr[31:12], 12'b0};
      end
      4'd4: begin
        dec_imm        = {XLEN{Instr[31]}};
        dec_imm[20:0]  = {Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};
      end
      4'd5: begin
        dec_imm        = {XLEN{Instr[31]}};
        dec_imm[12:0]  = {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
      end
      4'd6: begin
        dec_imm       = {XLEN{Instr[12]}};
        dec_imm[5:0]  = {Instr[12], Instr[6:2]};
      end
      4'd7: begin
        dec_imm[9:0] = {Instr[10:7], Instr[12:11], Instr[5], Instr[6], 2'b0};
      end
      4'd8: begin
        dec_imm        = {XLEN{Instr[12]}};
        dec_imm[11:0]  = {Instr[12], Instr[8], Instr[10:9], Instr[6], Instr[7],
                          Instr[2], Instr[11], Instr[5:3], 1'b0};
      end
      4'd9: begin
        dec_imm       = {XLEN{Instr[12]}};
        dec_imm[8:0]  = {Instr[12], Instr[6:5], Instr[2], Instr[11:10], Instr[4:3], 1'b0};
      end
      default: begin
        dec_imm     = '0;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // State register; reset and flush both leave the buffer empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and load selects; flush overrides any accept or drain.
  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (Flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            next_state   = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid  = 1'b1;
            next_state = FULL;
          end else if (drain) begin
            next_state = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            load_main_skid = 1'b1;
            next_state     = ONE;
          end
        end
        default: begin
          next_state = EMPTY;
        end
      endcase
    end
  end

  // Entry data registers; main is cleared at reset so the outputs read zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_imm     <= '0;
      main_illegal <= 1'b0;
      main_tag     <= '0;
      skid_imm     <= '0;
      skid_illegal <= 1'b0;
      skid_tag     <= '0;
    end else begin
      if (load_main_in) begin
        main_imm     <= dec_imm;
        main_illegal <= dec_illegal;
        main_tag     <= InTag;
      end else if (load_main_skid) begin
        main_imm     <= skid_imm;
        main_illegal <= skid_illegal;
        main_tag     <= skid_tag;
      end
      if (load_skid) begin
        skid_imm     <= dec_imm;
        skid_illegal <= dec_illegal;
        skid_tag     <= InTag;
      end
    end
  end

endmodule
